bin_bcd_spi: RTL and testbench

Parametrised successor to the combinational binary-to-BCD plus fixed-width SPI path.
- Accepts a WIDTH-bit binary value on a load handshake.
- Converts it to DIGITS BCD digits with a sequential double-dabble engine.
- Shifts the packed BCD frame MSB-first to a PMOD display over SPI mode 0.
- Sits between the factorial result and the board PMOD pins; reports busy/done/overflow to the top level.

---
 rtl/bin_bcd_spi.sv | 176 +++++++++++++++++
 tb/tb_bin_bcd_spi.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/bin_bcd_spi.sv
// Binary-to-BCD converter (sequential double-dabble) feeding an SPI mode-0 shifter for a PMOD display.
// Optional build macro BIN_BCD_SPI_LEADING_BLANK_EN replaces leading zero digits with the blank code 4'hF.
module bin_bcd_spi #(
    parameter int WIDTH   = 32,
    parameter int DIGITS  = 10,
    parameter int CLK_DIV = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ld_number,
    input  logic [WIDTH-1:0] number,
    output logic             busy,
    output logic             done,
    output logic             overflow,
    output logic             csn,
    output logic             mosi,
    output logic             sck
);
    localparam int FW     = 4 * DIGITS;
    localparam int HALVES = 2 * FW;
    localparam int CW     = $clog2(WIDTH + 1);
    localparam int DW     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int HW     = $clog2(HALVES);

    localparam logic [CW-1:0] STEP_LAST = CW'(WIDTH);
    localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);
    localparam logic [HW-1:0] HALF_LAST = HW'(HALVES - 1);

    typedef enum logic [1:0] {S_IDLE, S_CONVERT, S_FRAME, S_GAP} state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  bin_q, bin_d;
    logic [FW-1:0]     bcd_q, bcd_d;
    logic [FW-1:0]     sr_q, sr_d;
    logic [CW-1:0]     step_q, step_d;
    logic [DW-1:0]     div_q, div_d;
    logic [HW-1:0]     half_q, half_d;
    logic              ovf_q, ovf_d;
    logic              csn_q, csn_d;
    logic              sck_q, sck_d;
    logic              mosi_q, mosi_d;

    logic [FW-1:0]     bcd_adj;
    logic [FW-1:0]     frame_w;

    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
        assign bcd_adj[4*gi +: 4] = (bcd_q[4*gi +: 4] >= 4'd5) ? bcd_q[4*gi +: 4] + 4'd3
                                                              : bcd_q[4*gi +: 4];
    end

`ifdef BIN_BCD_SPI_LEADING_BLANK_EN
    // zero_above[gi]: digit gi and every digit above it are zero
    logic [DIGITS-1:1] zero_above;
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_blank
        if (gi == 0) begin : g_lsd
            assign frame_w[3:0] = bcd_q[3:0];
        end else begin : g_upper
            if (gi == DIGITS - 1) begin : g_top
                assign zero_above[gi] = (bcd_q[4*gi +: 4] == 4'd0);
            end else begin : g_mid
                assign zero_above[gi] = zero_above[gi+1] & (bcd_q[4*gi +: 4] == 4'd0);
            end
            assign frame_w[4*gi +: 4] = zero_above[gi] ? 4'hF : bcd_q[4*gi +: 4];
        end
    end
`else
    assign frame_w = bcd_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            bin_q   <= '0;
            bcd_q   <= '0;
            sr_q    <= '0;
            step_q  <= '0;
            div_q   <= '0;
            half_q  <= '0;
            ovf_q   <= 1'b0;
            csn_q   <= 1'b1;
            sck_q   <= 1'b0;
            mosi_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
            sr_q    <= sr_d;
            step_q  <= step_d;
            div_q   <= div_d;
            half_q  <= half_d;
            ovf_q   <= ovf_d;
            csn_q   <= csn_d;
            sck_q   <= sck_d;
            mosi_q  <= mosi_d;
        end
    end

    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        bcd_d   = bcd_q;
        sr_d    = sr_q;
        step_d  = step_q;
        div_d   = div_q;
        half_d  = half_q;
        ovf_d   = ovf_q;
        csn_d   = csn_q;
        sck_d   = sck_q;
        mosi_d  = mosi_q;
        unique case (state_q)
            S_IDLE: begin
                if (ld_number) begin
                    state_d = S_CONVERT;
                    bin_d   = number;
                    bcd_d   = '0;
                    step_d  = '0;
                    ovf_d   = 1'b0;
                end
            end
            S_CONVERT: begin
                // WIDTH shift steps, then one edge to load the frame and open CS
                if (step_q == STEP_LAST) begin
                    state_d = S_FRAME;
                    sr_d    = frame_w;
                    mosi_d  = frame_w[FW-1];
                    csn_d   = 1'b0;
                    sck_d   = 1'b0;
                    div_d   = '0;
                    half_d  = '0;
                end else begin
                    bcd_d  = {bcd_adj[FW-2:0], bin_q[WIDTH-1]};
                    bin_d  = {bin_q[WIDTH-2:0], 1'b0};
                    ovf_d  = ovf_q | bcd_adj[FW-1];
                    step_d = step_q + CW'(1);
                end
            end
            S_FRAME: begin
                if (div_q == DIV_LAST) begin
                    div_d  = '0;
                    half_d = half_q + HW'(1);
                    if (!half_q[0]) begin
                        sck_d = 1'b1;
                    end else if (half_q == HALF_LAST) begin
                        state_d = S_GAP;
                        sck_d   = 1'b0;
                        csn_d   = 1'b1;
                        mosi_d  = 1'b0;
                        half_d  = '0;
                    end else begin
                        sck_d  = 1'b0;
                        sr_d   = {sr_q[FW-2:0], 1'b0};
                        mosi_d = sr_q[FW-2];
                    end
                end else begin
                    div_d = div_q + DW'(1);
                end
            end
            S_GAP: begin
                if (div_q == DIV_LAST) begin
                    state_d = S_IDLE;
                    div_d   = '0;
                end else begin
                    div_d = div_q + DW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy     = (state_q != S_IDLE);
    assign done     = (state_q == S_GAP) && (div_q == DIV_LAST);
    assign overflow = ovf_q;
    assign csn      = csn_q;
    assign sck      = sck_q;
    assign mosi     = mosi_q;
endmodule

// File: tb/tb_bin_bcd_spi.sv
// Directed bench: DUT a (WIDTH=8, DIGITS=3, CLK_DIV=2) and DUT b (WIDTH=8, DIGITS=2, CLK_DIV=2).
module tb_bin_bcd_spi;
    logic       clk;
    logic       rst_n;
    logic       ld_a, ld_b;
    logic [7:0] num_a, num_b;
    logic       busy_a, done_a, ovf_a, csn_a, mosi_a, sck_a;
    logic       busy_b, done_b, ovf_b, csn_b, mosi_b, sck_b;

    int n_checks = 0;
    int n_errors = 0;

`ifdef BIN_BCD_SPI_LEADING_BLANK_EN
    localparam logic [11:0] EXP_0  = 12'hFF0;
    localparam logic [11:0] EXP_5  = 12'hFF5;
    localparam logic [11:0] EXP_7  = 12'hFF7;
    localparam logic [11:0] EXP_77 = 12'hF77;
`else
    localparam logic [11:0] EXP_0  = 12'h000;
    localparam logic [11:0] EXP_5  = 12'h005;
    localparam logic [11:0] EXP_7  = 12'h007;
    localparam logic [11:0] EXP_77 = 12'h077;
`endif
    // Edge indices counted from the accept edge (index 0)
    localparam int T_CSN    = 9;
    localparam int T_DONE_A = 8 + 8*3*2 + 2;
    localparam int T_DONE_B = 8 + 8*2*2 + 2;

    bin_bcd_spi #(.WIDTH(8), .DIGITS(3), .CLK_DIV(2)) u_a (
        .clk(clk), .rst_n(rst_n), .ld_number(ld_a), .number(num_a),
        .busy(busy_a), .done(done_a), .overflow(ovf_a),
        .csn(csn_a), .mosi(mosi_a), .sck(sck_a)
    );

    bin_bcd_spi #(.WIDTH(8), .DIGITS(2), .CLK_DIV(2)) u_b (
        .clk(clk), .rst_n(rst_n), .ld_number(ld_b), .number(num_b),
        .busy(busy_b), .done(done_b), .overflow(ovf_b),
        .csn(csn_b), .mosi(mosi_b), .sck(sck_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    logic [11:0] r_cap;
    int          r_tcsn, r_tdone, r_pulses, r_low, r_bgaps, r_frames;
    logic        r_ovf, r_done_after, r_busy_after;

    task automatic drive_ld(input bit sel, input logic v, input logic [7:0] n);
        if (sel) begin ld_b = v; num_b = n; end
        else     begin ld_a = v; num_a = n; end
    endtask

    // Runs one transaction from an aligned point (#1 after a posedge) and records what the pins did.
    task automatic run_txn(input bit sel, input logic [7:0] num, input int inj1, input int inj2,
                           input bit ld_on_done);
        logic c, c_prev, s, s_prev, m, b, d, o;
        r_cap = '0; r_tcsn = -1; r_tdone = -1; r_pulses = 0; r_low = 0; r_bgaps = 0; r_frames = 0;
        r_ovf = 1'b0; r_done_after = 1'b1; r_busy_after = 1'b1;
        drive_ld(sel, 1'b1, num);
        @(posedge clk); #1;
        drive_ld(sel, 1'b0, num);
        c_prev = sel ? csn_b : csn_a;
        s_prev = sel ? sck_b : sck_a;
        for (int t = 1; t <= 400 && r_tdone < 0; t++) begin
            if (t == inj1 || t == inj2) drive_ld(sel, 1'b1, 8'd99);
            @(posedge clk); #1;
            drive_ld(sel, 1'b0, num);
            c = sel ? csn_b  : csn_a;
            s = sel ? sck_b  : sck_a;
            m = sel ? mosi_b : mosi_a;
            b = sel ? busy_b : busy_a;
            d = sel ? done_b : done_a;
            o = sel ? ovf_b  : ovf_a;
            if (!c && c_prev) begin
                r_frames++;
                if (r_tcsn < 0) r_tcsn = t;
            end
            if (!c) r_low++;
            if (s && !s_prev) begin
                r_cap = {r_cap[10:0], m};
                r_pulses++;
            end
            if (!b) r_bgaps++;
            if (d) begin
                r_tdone = t;
                r_ovf   = o;
            end
            c_prev = c;
            s_prev = s;
        end
        if (r_tdone >= 0) begin
            if (ld_on_done) drive_ld(sel, 1'b1, 8'd0);
            @(posedge clk); #1;
            drive_ld(sel, 1'b0, num);
            r_done_after = sel ? done_b : done_a;
            r_busy_after = sel ? busy_b : busy_a;
        end
        $display("txn dut=%s num=%0d frame=%h t_csn=%0d t_done=%0d pulses=%0d cs_low=%0d ovf=%0b",
                 sel ? "b" : "a", num, r_cap, r_tcsn, r_tdone, r_pulses, r_low, r_ovf);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        ld_a = 1'b0; ld_b = 1'b0; num_a = '0; num_b = '0;
        #12;
        n_checks++; if (csn_a !== 1'b1)  begin n_errors++; $display("FAIL reset_csn got %b want 1", csn_a); end
        n_checks++; if (sck_a !== 1'b0)  begin n_errors++; $display("FAIL reset_sck got %b want 0", sck_a); end
        n_checks++; if (mosi_a !== 1'b0) begin n_errors++; $display("FAIL reset_mosi got %b want 0", mosi_a); end
        n_checks++; if (busy_a !== 1'b0) begin n_errors++; $display("FAIL reset_busy got %b want 0", busy_a); end
        n_checks++; if (done_a !== 1'b0) begin n_errors++; $display("FAIL reset_done got %b want 0", done_a); end
        n_checks++; if (ovf_a !== 1'b0)  begin n_errors++; $display("FAIL reset_ovf got %b want 0", ovf_a); end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_convert();
        run_txn(1'b0, 8'd120, -1, -1, 1'b0);
        n_checks++; if (r_cap !== 12'h120)      begin n_errors++; $display("FAIL conv120_frame got %h want 120", r_cap); end
        n_checks++; if (r_tcsn !== T_CSN)       begin n_errors++; $display("FAIL conv120_tcsn got %0d want %0d", r_tcsn, T_CSN); end
        n_checks++; if (r_tdone !== T_DONE_A)   begin n_errors++; $display("FAIL conv120_tdone got %0d want %0d", r_tdone, T_DONE_A); end
        n_checks++; if (r_pulses !== 12)        begin n_errors++; $display("FAIL conv120_pulses got %0d want 12", r_pulses); end
        n_checks++; if (r_low !== 48)           begin n_errors++; $display("FAIL conv120_cslow got %0d want 48", r_low); end
        n_checks++; if (r_ovf !== 1'b0)         begin n_errors++; $display("FAIL conv120_ovf got %b want 0", r_ovf); end
        n_checks++; if (r_done_after !== 1'b0)  begin n_errors++; $display("FAIL conv120_done_pulse got %b want 0", r_done_after); end
        n_checks++; if (r_busy_after !== 1'b0)  begin n_errors++; $display("FAIL conv120_busy_fall got %b want 0", r_busy_after); end
    endtask

    task automatic test_back_to_back();
        run_txn(1'b0, 8'd255, -1, -1, 1'b1);
        n_checks++; if (r_cap !== 12'h255)      begin n_errors++; $display("FAIL b2b255_frame got %h want 255", r_cap); end
        n_checks++; if (r_busy_after !== 1'b0)  begin n_errors++; $display("FAIL b2b_ld_on_done got busy %b want 0", r_busy_after); end
        run_txn(1'b0, 8'd0, -1, -1, 1'b0);
        n_checks++; if (r_cap !== EXP_0)        begin n_errors++; $display("FAIL b2b0_frame got %h want %h", r_cap, EXP_0); end
        n_checks++; if (r_tdone !== T_DONE_A)   begin n_errors++; $display("FAIL b2b0_tdone got %0d want %0d", r_tdone, T_DONE_A); end
    endtask

    task automatic test_overflow();
        run_txn(1'b1, 8'd120, -1, -1, 1'b0);
        n_checks++; if (r_cap !== 12'h020)      begin n_errors++; $display("FAIL ovf120_frame got %h want 20", r_cap); end
        n_checks++; if (r_ovf !== 1'b1)         begin n_errors++; $display("FAIL ovf120_flag got %b want 1", r_ovf); end
        n_checks++; if (ovf_b !== 1'b1)         begin n_errors++; $display("FAIL ovf_sticky got %b want 1", ovf_b); end
        n_checks++; if (r_tdone !== T_DONE_B)   begin n_errors++; $display("FAIL ovf120_tdone got %0d want %0d", r_tdone, T_DONE_B); end
        n_checks++; if (r_pulses !== 8)         begin n_errors++; $display("FAIL ovf120_pulses got %0d want 8", r_pulses); end
        run_txn(1'b1, 8'd42, -1, -1, 1'b0);
        n_checks++; if (r_cap !== 12'h042)      begin n_errors++; $display("FAIL ovf42_frame got %h want 42", r_cap); end
        n_checks++; if (r_ovf !== 1'b0)         begin n_errors++; $display("FAIL ovf42_flag got %b want 0", r_ovf); end
    endtask

    task automatic test_ignore_ld();
        run_txn(1'b0, 8'd77, 3, 20, 1'b0);
        n_checks++; if (r_cap !== EXP_77)       begin n_errors++; $display("FAIL ign_frame got %h want %h", r_cap, EXP_77); end
        n_checks++; if (r_frames !== 1)         begin n_errors++; $display("FAIL ign_frames got %0d want 1", r_frames); end
        n_checks++; if (r_bgaps !== 0)          begin n_errors++; $display("FAIL ign_busy_gaps got %0d want 0", r_bgaps); end
        n_checks++; if (r_tdone !== T_DONE_A)   begin n_errors++; $display("FAIL ign_tdone got %0d want %0d", r_tdone, T_DONE_A); end
    endtask

    task automatic test_reset_midframe();
        int   rises;
        logic s_prev;
        rises = 0;
        s_prev = 1'b0;
        drive_ld(1'b0, 1'b1, 8'd199);
        @(posedge clk); #1;
        drive_ld(1'b0, 1'b0, 8'd199);
        for (int t = 0; t < 200 && rises < 5; t++) begin
            @(posedge clk); #1;
            if (sck_a && !s_prev) rises++;
            s_prev = sck_a;
        end
        n_checks++; if (rises !== 5) begin n_errors++; $display("FAIL midrst_reach got %0d rises want 5", rises); end
        // Bit 4 of 0x199 is high, so mosi and sck are both 1 just before reset
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (csn_a !== 1'b1)  begin n_errors++; $display("FAIL midrst_csn got %b want 1", csn_a); end
        n_checks++; if (sck_a !== 1'b0)  begin n_errors++; $display("FAIL midrst_sck got %b want 0", sck_a); end
        n_checks++; if (mosi_a !== 1'b0) begin n_errors++; $display("FAIL midrst_mosi got %b want 0", mosi_a); end
        n_checks++; if (busy_a !== 1'b0) begin n_errors++; $display("FAIL midrst_busy got %b want 0", busy_a); end
        $display("txn dut=a num=199 reset at bit 4 csn=%b sck=%b mosi=%b busy=%b", csn_a, sck_a, mosi_a, busy_a);
        @(posedge clk); #3;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_txn(1'b0, 8'd7, -1, -1, 1'b0);
        n_checks++; if (r_cap !== EXP_7)        begin n_errors++; $display("FAIL midrst7_frame got %h want %h", r_cap, EXP_7); end
        n_checks++; if (r_tcsn !== T_CSN)       begin n_errors++; $display("FAIL midrst7_tcsn got %0d want %0d", r_tcsn, T_CSN); end
        n_checks++; if (r_tdone !== T_DONE_A)   begin n_errors++; $display("FAIL midrst7_tdone got %0d want %0d", r_tdone, T_DONE_A); end
    endtask

    task automatic test_digits();
        run_txn(1'b0, 8'd5, -1, -1, 1'b0);
        n_checks++; if (r_cap !== EXP_5)   begin n_errors++; $display("FAIL dig5_frame got %h want %h", r_cap, EXP_5); end
        run_txn(1'b0, 8'd100, -1, -1, 1'b0);
        n_checks++; if (r_cap !== 12'h100) begin n_errors++; $display("FAIL dig100_frame got %h want 100", r_cap); end
        n_checks++; if (r_ovf !== 1'b0)    begin n_errors++; $display("FAIL dig100_ovf got %b want 0", r_ovf); end
    endtask

    initial begin
        test_reset();
        test_convert();
        test_back_to_back();
        test_overflow();
        test_ignore_ld();
        test_reset_midframe();
        test_digits();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
